// File: rtl/cpu_oam_dma.sv
// Sprite DMA: a CPU write to TRIGGER_ADDR stalls the CPU and copies XFER_LEN bytes from {page,idx} to DEST_ADDR.
// Latency: 1 halt cycle (+1 align cycle with CPU_OAM_DMA_ALIGN_EN) then read/write pairs; outputs combinational from state.
// Backpressure: clock_en=0 freezes all state; dma_active tells the bus mux to stall the CPU.
module cpu_oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004,
    parameter int          XFER_LEN     = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clock_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r_en,
    input  logic [7:0]  cpu_w_data,
    input  logic [7:0]  mem_r_data,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_r_en,
    output logic [7:0]  dma_w_data,
    output logic        dma_done
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t     state;
    logic [7:0] page;
    logic [7:0] idx;
`ifdef CPU_OAM_DMA_ALIGN_EN
    logic       parity;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
`ifdef CPU_OAM_DMA_ALIGN_EN
            parity <= 1'b0;
`endif
        end else if (clock_en) begin
`ifdef CPU_OAM_DMA_ALIGN_EN
            parity <= ~parity;
`endif
            case (state)
                S_IDLE: begin
                    if (!cpu_r_en && cpu_addr == TRIGGER_ADDR) begin
                        page  <= cpu_w_data;
                        idx   <= 8'h00;
                        state <= S_HALT;
                    end
                end
                S_HALT: begin
`ifdef CPU_OAM_DMA_ALIGN_EN
                    // An extra dummy cycle keeps the first real read on an even cycle
                    state <= parity ? S_READ : S_ALIGN;
`else
                    state <= S_READ;
`endif
                end
                S_ALIGN: state <= S_READ;
                S_READ:  state <= S_WRITE;
                S_WRITE: begin
                    if (idx == LAST_IDX) begin
                        state <= S_IDLE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= S_READ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        dma_active = 1'b0;
        dma_addr   = 16'h0000;
        dma_r_en   = 1'b1;
        dma_w_data = 8'h00;
        dma_done   = 1'b0;
        case (state)
            S_HALT, S_ALIGN: begin
                dma_active = 1'b1;
                dma_addr   = {page, 8'h00};
            end
            S_READ: begin
                dma_active = 1'b1;
                dma_addr   = {page, idx};
            end
            S_WRITE: begin
                dma_active = 1'b1;
                dma_r_en   = 1'b0;
                dma_addr   = DEST_ADDR;
                dma_w_data = mem_r_data;
                dma_done   = (idx == LAST_IDX);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_oam_dma.sv
// Bench for cpu_oam_dma: trigger decode table, directed corner sequences and randomized transfers
// compared cycle-by-cycle against an expected bus trace built from the transfer rules.
module tb_cpu_oam_dma;

`ifdef CPU_OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        clock_en;
    logic [15:0] cpu_addr;
    logic        cpu_r_en;
    logic [7:0]  cpu_w_data;
    logic [7:0]  mem_r_data;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_r_en;
    logic [7:0]  dma_w_data;
    logic        dma_done;

    cpu_oam_dma dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clock_en   (clock_en),
        .cpu_addr   (cpu_addr),
        .cpu_r_en   (cpu_r_en),
        .cpu_w_data (cpu_w_data),
        .mem_r_data (mem_r_data),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_r_en   (dma_r_en),
        .dma_w_data (dma_w_data),
        .dma_done   (dma_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic        r_en;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        done;
    } bus_t;

    typedef struct {
        logic [15:0] addr;
        logic        r_en;
        logic [7:0]  wd;
        logic        ce;
        logic        exp_act;
        logic [15:0] exp_addr;
    } vec_t;

    logic [7:0] mem [0:65535];
    bus_t       trace[$];
    int         ce_count;
    int         checks;
    int         errors;

    // Memory latches the muxed bus address; data appears one enabled cycle later
    always @(posedge clock) begin
        if (reset_n && clock_en) begin
            if (dma_active ? dma_r_en : cpu_r_en)
                mem_r_data <= mem[dma_active ? dma_addr : cpu_addr];
        end
    end

    always @(posedge clock) begin
        if (!reset_n) begin
            ce_count <= 0;
        end else if (clock_en) begin
            ce_count <= ce_count + 1;
            if (dma_active)
                trace.push_back(mk(dma_r_en, dma_addr, dma_w_data, dma_done));
        end
    end

    function automatic bus_t mk(logic r, logic [15:0] a, logic [7:0] d, logic dn);
        bus_t b;
        b.r_en = r;
        b.addr = a;
        b.data = d;
        b.done = dn;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_bus();
        clock_en   = 1'b1;
        cpu_addr   = 16'h0000;
        cpu_r_en   = 1'b1;
        cpu_w_data = 8'h00;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_active"}, dma_active, 0);
        check({tag, "_idle_r_en"}, dma_r_en, 1);
        check({tag, "_idle_addr"}, dma_addr, 0);
        check({tag, "_idle_done"}, dma_done, 0);
    endtask

    // One transfer: expected trace = dummy read(s) of {pg,00}, then read {pg,i} / write DEST mem[{pg,i}]
    task automatic run_xfer(input logic [7:0] pg, input bit rnd, input bit gate10,
                            input string tag, output int act_len);
        bus_t exp_q[$];
        int   halt_par, cyc, bad, first_bad, n_dummy;
        bit   gated;
        halt_par = (ce_count + 1) % 2;
        n_dummy  = (ALIGN_ON && halt_par == 0) ? 2 : 1;
        for (int d = 0; d < n_dummy; d++)
            exp_q.push_back(mk(1'b1, {pg, 8'h00}, 8'h00, 1'b0));
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(mk(1'b1, {pg, 8'(i)}, 8'h00, 1'b0));
            exp_q.push_back(mk(1'b0, 16'h2004, mem[{pg, 8'(i)}], i == 255));
        end
        trace.delete();
        clock_en   = 1'b1;
        cpu_addr   = 16'h4014;
        cpu_r_en   = 1'b0;
        cpu_w_data = pg;
        step();
        cyc   = 0;
        gated = 1'b0;
        while (dma_active && cyc < 4000) begin
            if (gate10 && !gated && dma_r_en && dma_addr == {pg, 8'h10}) begin
                gated    = 1'b1;
                clock_en = 1'b0;
                for (int g = 0; g < 7; g++) begin
                    step();
                    check({tag, "_gate_hold_addr"}, dma_addr, {pg, 8'h10});
                end
            end
            clock_en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd) begin
                cpu_addr   = 16'($urandom);
                cpu_r_en   = 1'($urandom);
                cpu_w_data = 8'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    cpu_addr   = 16'h4014;
                    cpu_r_en   = 1'b0;
                    cpu_w_data = 8'h07;
                end
            end else if (cyc == 40) begin
                cpu_addr   = 16'h4014;
                cpu_r_en   = 1'b0;
                cpu_w_data = 8'h07;
            end else begin
                cpu_addr = 16'h0000;
                cpu_r_en = 1'b1;
            end
            step();
            cyc++;
        end
        check({tag, "_in_budget"}, cyc < 4000, 1);
        act_len = trace.size();
        check({tag, "_len"}, act_len, exp_q.size());
        bad       = 0;
        first_bad = -1;
        for (int k = 0; k < exp_q.size() && k < trace.size(); k++) begin
            if (trace[k] !== exp_q[k]) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        check({tag, "_trace_diffs"}, bad, 0);
        if (bad != 0)
            $display("  %s first differing cycle %0d got %h want %h", tag, first_bad,
                     trace[first_bad], exp_q[first_bad]);
        quiet_bus();
        check_idle(tag);
    endtask

    initial begin
        vec_t vecs[8];
        int   len, want_len, last_rd, budget;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] a;
            a = 16'(i);
            mem[a] = (a[15:8] == 8'h02) ? (a[7:0] ^ 8'h5A) : 8'($urandom);
        end
        mem_r_data = 8'h00;
        quiet_bus();
        reset_n = 1'b0;
        step();
        step();
        check("reset_active", dma_active, 0);
        check("reset_addr", dma_addr, 0);
        check("reset_r_en", dma_r_en, 1);
        check("reset_w_data", dma_w_data, 0);
        check("reset_done", dma_done, 0);
        reset_n = 1'b1;
        step();

        vecs[0] = '{16'h4014, 1'b0, 8'h02, 1'b1, 1'b1, 16'h0200};
        vecs[1] = '{16'h4014, 1'b1, 8'h02, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{16'h4015, 1'b0, 8'h02, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{16'h0014, 1'b0, 8'h02, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{16'h4014, 1'b0, 8'hFF, 1'b1, 1'b1, 16'hFF00};
        vecs[5] = '{16'h4014, 1'b0, 8'h33, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{16'h2004, 1'b0, 8'h07, 1'b1, 1'b0, 16'h0000};
        vecs[7] = '{16'h4014, 1'b0, 8'h80, 1'b1, 1'b1, 16'h8000};
        for (int v = 0; v < 8; v++) begin
            cpu_addr   = vecs[v].addr;
            cpu_r_en   = vecs[v].r_en;
            cpu_w_data = vecs[v].wd;
            clock_en   = vecs[v].ce;
            step();
            quiet_bus();
            check($sformatf("vec%0d_active", v), dma_active, vecs[v].exp_act);
            check($sformatf("vec%0d_addr", v), dma_addr, vecs[v].exp_addr);
            pulse_reset();
        end

        run_xfer(8'h02, 1'b0, 1'b0, "basic", len);
        step();
        run_xfer(8'h02, 1'b0, 1'b1, "gate", len);

        for (int p = 0; p < 2; p++) begin
            if ((ce_count % 2) != p) step();
            want_len = 513 + ((ALIGN_ON && ((ce_count + 1) % 2) == 0) ? 1 : 0);
            run_xfer(8'h02, 1'b0, 1'b0, $sformatf("align_p%0d", p), len);
            check($sformatf("align_p%0d_active_cycles", p), len, want_len);
        end

        clock_en   = 1'b1;
        cpu_addr   = 16'h4014;
        cpu_r_en   = 1'b0;
        cpu_w_data = 8'h02;
        step();
        quiet_bus();
        budget = 0;
        while (!(dma_active && dma_r_en && dma_addr == 16'h0280) && budget < 1000) begin
            step();
            budget++;
        end
        check("midreset_reached_idx80", budget < 1000, 1);
        reset_n = 1'b0;
        #1;
        check("midreset_active", dma_active, 0);
        check("midreset_r_en", dma_r_en, 1);
        check("midreset_addr", dma_addr, 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        run_xfer(8'h02, 1'b0, 1'b0, "restart", len);

        run_xfer(8'hFF, 1'b0, 1'b0, "pageff", len);
        last_rd = 0;
        foreach (trace[k]) if (trace[k].r_en) last_rd = int'(trace[k].addr);
        check("pageff_last_read", last_rd, 32'h0000FFFF);

        for (int r = 0; r < 5; r++) begin
            int n_idle;
            n_idle = $urandom_range(0, 6);
            for (int c = 0; c < n_idle; c++) begin
                clock_en   = 1'($urandom);
                cpu_addr   = 16'($urandom);
                cpu_r_en   = 1'($urandom);
                cpu_w_data = 8'($urandom);
                if (!cpu_r_en && cpu_addr == 16'h4014) cpu_addr = 16'h4015;
                step();
            end
            run_xfer(8'($urandom), 1'b1, 1'b0, $sformatf("rand%0d", r), len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
